// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a combinational-read, whole-word-write data memory.
// Latency: fault response 1 cycle after accept, loads/SW 2 cycles, SB/SH (read-modify-write) 3 cycles.
// Backpressure: req_ready is high only in IDLE; a request offered while busy is ignored and must be held.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_memWrite,
    input  logic [31:0] mem_readData
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR
    } state_t;

    // The store/load direction is carried by the state, so only the operands are held.
    typedef struct packed {
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state_q;
    state_t      state_d;
    req_t        req_q;
    logic [31:0] merge_q;

    logic        accept;
    logic        f3_illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic [31:0] word_last;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merge_d;

    // ---------------- request qualification ----------------
    assign accept    = req_valid && (state_q == IDLE);
    assign word_last = {req_addr[31:2], 2'b00} + 32'd3;

    always_comb begin
        f3_illegal = 1'b0;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: f3_illegal = 1'b1;
            default:                f3_illegal = 1'b0;
        endcase
        if (req_write && req_funct3[2]) begin
            f3_illegal = 1'b1;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) begin
            misaligned = 1'b1;
        end
        if (req_funct3 == F3_W && req_addr[1:0] != 2'b00) begin
            misaligned = 1'b1;
        end
    end

    assign out_of_range = (word_last >= 32'(MEM_BYTES));
    assign fault        = f3_illegal || misaligned || out_of_range;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !fault) begin
                    if (!req_write) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD:    state_d = IDLE;
            STORE:   state_d = IDLE;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- memory-side outputs ----------------
    assign req_ready    = (state_q == IDLE);
    assign mem_address  = {req_q.addr[31:2], 2'b00};
    assign mem_memWrite = (state_q == STORE) || (state_q == RMW_WR);

    always_comb begin
        mem_writeData = '0;
        case (state_q)
            STORE:   mem_writeData = req_q.wdata;
            RMW_WR:  mem_writeData = merge_q;
            default: mem_writeData = '0;
        endcase
    end

    // ---------------- load lane select and extension ----------------
    always_comb begin
        lane_b = mem_readData[7:0];
        case (req_q.addr[1:0])
            2'd0:    lane_b = mem_readData[7:0];
            2'd1:    lane_b = mem_readData[15:8];
            2'd2:    lane_b = mem_readData[23:16];
            default: lane_b = mem_readData[31:24];
        endcase
        lane_h = req_q.addr[1] ? mem_readData[31:16] : mem_readData[15:0];
    end

    always_comb begin
        load_ext = mem_readData;
        case (req_q.funct3)
            F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_ext = {24'h0, lane_b};
            F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_ext = {16'h0, lane_h};
            default: load_ext = mem_readData;
        endcase
    end

    // ---------------- sub-word store merge ----------------
    always_comb begin
        merge_d = mem_readData;
        if (req_q.funct3 == F3_H) begin
            if (req_q.addr[1]) begin
                merge_d[31:16] = req_q.wdata[15:0];
            end else begin
                merge_d[15:0] = req_q.wdata[15:0];
            end
        end else begin
            case (req_q.addr[1:0])
                2'd0:    merge_d[7:0]   = req_q.wdata[7:0];
                2'd1:    merge_d[15:8]  = req_q.wdata[7:0];
                2'd2:    merge_d[23:16] = req_q.wdata[7:0];
                default: merge_d[31:24] = req_q.wdata[7:0];
            endcase
        end
    end

    // ---------------- request latch and response ----------------
    // Reset drops any pending response; a write already in STORE/RMW_WR still lands
    // because the memory samples mem_memWrite on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q      <= '0;
            merge_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            if (accept) begin
                req_q.funct3 <= req_funct3;
                req_q.addr   <= req_addr;
                req_q.wdata  <= req_wdata;
                if (fault) begin
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b1;
                end
            end
            case (state_q)
                LOAD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_ext;
                end
                STORE, RMW_WR: begin
                    resp_valid <= 1'b1;
                end
                RMW_RD: begin
                    merge_q <= merge_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory on the memory port, reference byte model
// feeding a queue of expected responses (data, fault, cycle) popped when resp_valid is seen.
// Requests are offered at the falling edge and held until accepted.
module tb_mem_access_unit;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_memWrite;
    logic [31:0] mem_readData;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_address  (mem_address),
        .mem_writeData(mem_writeData),
        .mem_memWrite (mem_memWrite),
        .mem_readData (mem_readData)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       mem_clear;
    int         cyc = 0;
    int         wr_count = 0;
    int         checks = 0;
    int         failures = 0;

    // ---------------- attached data memory ----------------
    always_comb begin
        if (mem_address < 32'(MEM_BYTES)) begin
            mem_readData = {mem[mem_address[9:0] + 10'd3], mem[mem_address[9:0] + 10'd2],
                            mem[mem_address[9:0] + 10'd1], mem[mem_address[9:0]]};
        end else begin
            mem_readData = '0;
        end
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
        end else if (mem_memWrite && mem_address < 32'(MEM_BYTES)) begin
            mem[mem_address[9:0]]          <= mem_writeData[7:0];
            mem[mem_address[9:0] + 10'd1]  <= mem_writeData[15:8];
            mem[mem_address[9:0] + 10'd2]  <= mem_writeData[23:16];
            mem[mem_address[9:0] + 10'd3]  <= mem_writeData[31:24];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_memWrite) wr_count <= wr_count + 1;
    end

    // ---------------- response scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp: got rdata=%h fault=%b at cycle %0d, required no response",
                         resp_rdata, resp_fault, cyc);
            end else begin
                e = exp_q.pop_front();
                checks += 3;
                if (resp_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL resp_rdata: got %h, required %h", resp_rdata, e.rdata);
                end
                if (resp_fault !== e.fault) begin
                    failures++;
                    $display("FAIL resp_fault: got %b, required %b", resp_fault, e.fault);
                end
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL resp_cycle: got cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic bit ref_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        longint last;
        last = longint'({a[31:2], 2'b00}) + 3;
        return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (wr && f3[2]) ||
               ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00) ||
               (last >= longint'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int         i;
        logic [7:0] b;
        logic [15:0] h;
        i = int'(a[9:0]);
        case (f3)
            3'd0: begin b = ref_mem[i]; return {{24{b[7]}}, b}; end
            3'd4: begin b = ref_mem[i]; return {24'h0, b}; end
            3'd1: begin h = {ref_mem[i+1], ref_mem[i]}; return {{16{h[15]}}, h}; end
            3'd5: begin h = {ref_mem[i+1], ref_mem[i]}; return {16'h0, h}; end
            default: return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
        endcase
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int i;
        i = int'(a[9:0]);
        ref_mem[i] = d[7:0];
        if (f3 != 3'd0) ref_mem[i+1] = d[15:8];
        if (f3 == 3'd2) begin
            ref_mem[i+2] = d[23:16];
            ref_mem[i+3] = d[31:24];
        end
    endfunction

    // Offer a request, wait for acceptance, optionally record the expected response.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input bit hold, input bit track, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        acc = cyc + 1;
        if (track) begin
            e.rdata = '0;
            e.fault = ref_fault(wr, f3, a);
            e.cyc   = acc;
            if (!e.fault) begin
                if (!wr) begin
                    e.rdata = ref_load(f3, a);
                    e.cyc   = acc + 1;
                end else begin
                    ref_store(f3, a, d);
                    e.cyc = (f3 == 3'd2) ? acc + 1 : acc + 2;
                end
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (!hold) begin
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        reset = 1'b1;
        mem_clear = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 mem_clear = 1'b0;
        @(negedge clk);
        checks += 4;
        if ({req_ready, resp_valid, resp_fault, mem_memWrite} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl: ready/valid/fault/we=%b, required 1000",
                     {req_ready, resp_valid, resp_fault, mem_memWrite});
        end
        if (resp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h, required 0", resp_rdata);
        end
        if (mem_address !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem_address: got %h, required 0", mem_address);
        end
        if (mem_writeData !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem_writeData: got %h, required 0", mem_writeData);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_store_load();
        int acc;
        int w0;
        w0 = wr_count;
        issue(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 1'b0, 1'b1, acc);
        drain();
        checks++;
        if (wr_count - w0 != 1) begin
            failures++;
            $display("FAIL sw_write_cycles: got %0d write cycles, required 1", wr_count - w0);
        end
        issue(1'b0, 3'd2, 32'h8, 32'h0, 1'b0, 1'b1, acc);
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL store_load_drain: %0d responses missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_extension();
        logic [2:0]  f3s [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd1, 3'd0, 3'd5};
        logic [31:0] adr [7] = '{32'hB, 32'hB, 32'hA, 32'h8, 32'h8, 32'h8, 32'hA};
        int acc;
        for (int i = 0; i < 7; i++) issue(1'b0, f3s[i], adr[i], 32'h0, 1'b0, 1'b1, acc);
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL extension_drain: %0d responses missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_subword_store();
        int acc;
        int w0;
        logic [31:0] word;
        w0 = wr_count;
        issue(1'b1, 3'd0, 32'h9, 32'h00000012, 1'b0, 1'b1, acc);
        issue(1'b0, 3'd2, 32'h8, 32'h0, 1'b0, 1'b1, acc);
        issue(1'b1, 3'd1, 32'hA, 32'h00005555, 1'b0, 1'b1, acc);
        issue(1'b0, 3'd2, 32'h8, 32'h0, 1'b0, 1'b1, acc);
        drain();
        word = {mem[11], mem[10], mem[9], mem[8]};
        checks += 2;
        if (wr_count - w0 != 2) begin
            failures++;
            $display("FAIL rmw_write_cycles: got %0d write cycles, required 2", wr_count - w0);
        end
        if (word !== 32'h555512EF) begin
            failures++;
            $display("FAIL rmw_word: memory word 0x8 is %h, required 555512ef", word);
        end
    endtask

    task automatic test_faults();
        logic        wrs [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [6] = '{3'd5, 3'd2, 3'd2, 3'd3, 3'd4, 3'd2};
        logic [31:0] adr [6] = '{32'h9, 32'h6, 32'h400, 32'h0, 32'h10, 32'h3FC};
        int acc;
        int w0;
        w0 = wr_count;
        for (int i = 0; i < 6; i++) issue(wrs[i], f3s[i], adr[i], 32'hFFFFFFFF, 1'b0, 1'b1, acc);
        drain();
        checks++;
        if (wr_count != w0) begin
            failures++;
            $display("FAIL fault_no_write: got %0d write cycles, required 0", wr_count - w0);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        int a1;
        int a2;
        issue(1'b0, 3'd2, 32'h8, 32'h0, 1'b1, 1'b1, a0);
        issue(1'b1, 3'd2, 32'h10, 32'h11223344, 1'b1, 1'b1, a1);
        issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 1'b1, a2);
        drain();
        checks += 2;
        if (a1 - a0 != 2) begin
            failures++;
            $display("FAIL b2b_spacing_1: got %0d cycles, required 2", a1 - a0);
        end
        if (a2 - a1 != 2) begin
            failures++;
            $display("FAIL b2b_spacing_2: got %0d cycles, required 2", a2 - a1);
        end
    endtask

    task automatic test_reset_rmw_rd();
        int acc;
        int w0;
        logic [31:0] word;
        w0 = wr_count;
        issue(1'b1, 3'd0, 32'h9, 32'h00000077, 1'b0, 1'b0, acc);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        word = {mem[11], mem[10], mem[9], mem[8]};
        checks += 3;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_rd_ready: got %b, required 1", req_ready);
        end
        if (wr_count != w0) begin
            failures++;
            $display("FAIL rst_rd_no_write: got %0d write cycles, required 0", wr_count - w0);
        end
        if (word !== ref_load(3'd2, 32'h8)) begin
            failures++;
            $display("FAIL rst_rd_word: got %h, required %h", word, ref_load(3'd2, 32'h8));
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_rmw_wr();
        int acc;
        logic [31:0] word;
        issue(1'b1, 3'd0, 32'h8, 32'h000000A5, 1'b0, 1'b0, acc);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ref_store(3'd0, 32'h8, 32'h000000A5);
        @(negedge clk);
        word = {mem[11], mem[10], mem[9], mem[8]};
        checks++;
        if (word !== ref_load(3'd2, 32'h8)) begin
            failures++;
            $display("FAIL rst_wr_word: got %h, required %h", word, ref_load(3'd2, 32'h8));
        end
        repeat (4) @(negedge clk);
        issue(1'b0, 3'd2, 32'h8, 32'h0, 1'b0, 1'b1, acc);
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_wr_drain: %0d responses missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_extension();
        test_subword_store();
        test_faults();
        test_back_to_back();
        test_reset_rmw_rd();
        test_reset_rmw_wr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
